uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-direction counterpart of the team's uart_tx.
- Sits between the USB-UART bridge RX pin and loopback/user logic.
- Default rate is 9600 baud at 12 MHz.
- Outputs a parallel byte with a one-cycle valid strobe, and flags framing errors.

Parameters:
CLKS_PER_BIT, 1250, clk cycles per bit (12 MHz / 9600); legal range 16..2047.
HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit falling edge to the start-bit centre check.

Ports:
clk  input  1  system clock (12 MHz)
rst  input  1  reset; asynchronous, active-high (one clock; reset is asynchronous and active-high)
rx  input  1  serial line, idle high, asynchronous to clk
data_o  output  8  last correctly received byte
rx_done  output  1  one-cycle pulse: data_o updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset values:
  - data_o=8'h00, rx_done=0, frame_err=0, busy=0.
  - State=IDLE, counters=0.
  - Synchronizer flops=1 (line treated as idle).
- Input sync: rx passes through 2 flops to give rx_s. All decisions use rx_s only. This adds 2 cycles of latency.
- 11-bit baud counter bcnt; 3-bit bit index bidx; 8-bit shift register sh.
- States:
  - IDLE: if rx_s==0, go to START with bcnt=0.
  - START: bcnt increments each cycle. At bcnt==HALF_BIT-1:
    - rx_s==0: valid start bit; go to DATA with bcnt=0, bidx=0.
    - rx_s==1: glitch; return to IDLE with no output pulse.
  - DATA: bcnt increments. At bcnt==CLKS_PER_BIT-1 (bit centre):
    - sh <= {rx_s, sh[7:1]} (LSB first); bcnt=0.
    - If bidx==7, go to STOP; else bidx+1.
  - STOP: at bcnt==CLKS_PER_BIT-1, sample rx_s:
    - 1: data_o<=sh, rx_done=1 for exactly one cycle, go to IDLE.
    - 0: frame_err=1 for one cycle, data_o unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This stops a held-low line from re-triggering as a start bit.
- Latency: rx_done asserts 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the rx falling edge. At defaults this is 11,877 cycles.
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit centre, so a start edge half a bit later is caught.
  - No idle gap is required between frames.
- rx_done and frame_err are mutually exclusive and never high in consecutive cycles.
- data_o holds its value until the next good frame.
- rst asserted mid-frame: everything returns to reset values immediately, with no pulse.
  - After release, a frame already in progress is not resynchronized until the line next sits high and then falls.
  - If rx is low at release, the block enters START and rejects or accepts per the START rule.
- Counter widths must hold CLKS_PER_BIT-1 without wrap. bcnt is never compared against CLKS_PER_BIT itself.

Test Plan:
- Send 0xA5 as 8N1 at 1250 cycles/bit after 20 idle cycles -> single rx_done pulse at 11,877±1 cycles after the falling edge; data_o=8'hA5; frame_err never high.
- Low glitch of 300 cycles on idle rx -> START aborts at the half-bit check; no rx_done, no frame_err; busy drops within 630 cycles.
- Send 0x3C with the stop bit driven low, then rx held low 3000 cycles, then high -> one frame_err pulse; data_o keeps its previous value; no second frame detected until rx returns high.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three rx_done pulses spaced 12,500 cycles apart (10 bits × 1250); data_o=00, then FF, then 55.
- Assert rst during bit 4 of 0x81, release, then send 0x7E -> outputs zero during reset; next rx_done carries data_o=8'h7E; no pulse for the aborted frame.
- Baud tolerance: send 0xC3 with bit period 1225 and again with 1275 (±2%) -> data_o=8'hC3 both times, no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, the receive-side partner of uart_tx.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   rx        serial line, idle high, asynchronous to clk
//   data_o    last correctly received byte (held until the next good frame)
//   rx_done   one-cycle pulse: data_o updated this cycle
//   frame_err one-cycle pulse: stop bit sampled low (data_o left unchanged)
//   busy      high while a frame is in progress (any state other than idle)
//
// Sampling: every decision uses the double-synchronised rx_s. The start bit is
// confirmed at its centre (HALF_BIT cycles after the edge); every following
// bit is then sampled one full bit period later, which lands on its centre.

module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 1250,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_o,
   output logic       rx_done,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [10:0] BitEnd  = 11'(CLKS_PER_BIT - 1);
   localparam logic [10:0] HalfEnd = 11'(HALF_BIT - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e      state_q, state_d;
   logic [10:0] bcnt_q, bcnt_d;
   logic [2:0]  bidx_q, bidx_d;
   logic [7:0]  sh_q, sh_d;
   logic [7:0]  data_q, data_d;
   logic        rx_done_q, rx_done_d;
   logic        frame_err_q, frame_err_d;
   logic        rx_meta_q, rx_s_q;

   // Synchroniser resets to 1 so the line looks idle straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bcnt_q      <= '0;
         bidx_q      <= '0;
         sh_q        <= '0;
         data_q      <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         bidx_q      <= bidx_d;
         sh_q        <= sh_d;
         data_q      <= data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      bidx_d      = bidx_q;
      sh_d        = sh_q;
      data_d      = data_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               state_d = StStart;
               bcnt_d  = '0;
            end
         end
         StStart: begin
            if (bcnt_q == HalfEnd) begin
               bcnt_d  = '0;
               bidx_d  = '0;
               // Line back high at the start-bit centre: treat as a glitch.
               state_d = rx_s_q ? StIdle : StData;
            end else begin
               bcnt_d = bcnt_q + 11'd1;
            end
         end
         StData: begin
            if (bcnt_q == BitEnd) begin
               sh_d   = {rx_s_q, sh_q[7:1]};
               bcnt_d = '0;
               if (bidx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bidx_d = bidx_q + 3'd1;
               end
            end else begin
               bcnt_d = bcnt_q + 11'd1;
            end
         end
         StStop: begin
            if (bcnt_q == BitEnd) begin
               bcnt_d = '0;
               if (rx_s_q) begin
                  data_d    = sh_q;
                  rx_done_d = 1'b1;
                  state_d   = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end else begin
               bcnt_d = bcnt_q + 11'd1;
            end
         end
         StBreak: begin
            // A held-low line must go high before a new start edge counts.
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign data_o    = data_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx. A reference model
// turns every transmitted frame into an expected event (good byte or framing
// error, expected data_o, cycle of the falling edge); a monitor records the
// pulses the receiver actually produces, and the two lists are compared.

module tb_uart_rx;

   localparam int CPB  = 40;
   localparam int HALF = CPB / 2;
   localparam int LAT  = 2 + HALF + 9 * CPB;

   typedef struct {
      bit         kind;   // 0: rx_done, 1: frame_err
      logic [7:0] data;
      int         cyc;
   } evt_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data_o;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] last_good = 8'h00;
   evt_t       exp_q[$];
   evt_t       act_q[$];
   evt_t       mon_e;
   bit         prev_pulse = 1'b0;

   uart_rx #(
      .CLKS_PER_BIT(CPB),
      .HALF_BIT    (HALF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .data_o   (data_o),
      .rx_done  (rx_done),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one 8N1 frame with the given bit period; when tracked, the model
   // records what the receiver must report for it.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int period,
                             input bit track);
      evt_t e;
      if (track) begin
         e.kind = !stop;
         e.data = stop ? b : last_good;
         e.cyc  = cyc + 1;  // first clock edge that sees the falling edge
         exp_q.push_back(e);
         if (stop) last_good = b;
      end
      rx = 1'b0;
      wait_cyc(period);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(period);
      end
      rx = stop;
      wait_cyc(period);
   endtask

   task automatic compare_events(input string tag);
      int n;
      int lat;
      check_eq({tag, "_count"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_kind"}, 32'(act_q[i].kind), 32'(exp_q[i].kind));
         check_eq({tag, "_data"}, 32'(act_q[i].data), 32'(exp_q[i].data));
         lat = act_q[i].cyc - exp_q[i].cyc;
         check_eq({tag, "_lat"}, (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
      end
      exp_q.delete();
      act_q.delete();
   endtask

   // Pulse monitor: records every rx_done/frame_err and checks they never
   // overlap and never appear in consecutive cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && (rx_done || frame_err)) begin
            check_eq("pulse_excl", 32'(rx_done && frame_err), 0);
            check_eq("pulse_gap", 32'(prev_pulse), 0);
            mon_e.kind = frame_err;
            mon_e.data = data_o;
            mon_e.cyc  = cyc;
            act_q.push_back(mon_e);
         end
         prev_pulse = !rst && (rx_done || frame_err);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rb;
      int         gap;
      int         per;

      rst = 1'b1;
      rx  = 1'b1;
      wait_cyc(3);
      check_eq("rst_data", 32'(data_o), 0);
      check_eq("rst_done", 32'(rx_done), 0);
      check_eq("rst_ferr", 32'(frame_err), 0);
      check_eq("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      wait_cyc(20);
      check_eq("idle_busy", 32'(busy), 0);

      // Single frame, latency and data.
      send_frame(8'hA5, 1'b1, CPB, 1'b1);
      wait_cyc(2);
      compare_events("a5");
      check_eq("a5_data", 32'(data_o), 32'h A5);

      // Short low glitch: start check fails, nothing reported.
      rx = 1'b0;
      wait_cyc(5);
      check_eq("glitch_busy", 32'(busy), 1);
      wait_cyc(HALF / 2 - 5);
      rx = 1'b1;
      wait_cyc(2 * HALF);
      check_eq("glitch_idle", 32'(busy), 0);
      compare_events("glitch");

      // Bad stop bit then a held-low line.
      send_frame(8'h3C, 1'b0, CPB, 1'b1);
      wait_cyc(3 * CPB);
      check_eq("break_busy", 32'(busy), 1);
      compare_events("break");
      rx = 1'b1;
      wait_cyc(5);
      check_eq("break_idle", 32'(busy), 0);
      check_eq("break_data", 32'(data_o), 32'(last_good));
      send_frame(8'h96, 1'b1, CPB, 1'b1);
      wait_cyc(2);
      compare_events("recover");

      // Random bytes, random gaps, bit period within a few percent.
      for (int k = 0; k < 4; k++) begin
         rb  = 8'($urandom);
         gap = $urandom_range(0, 30);
         per = $urandom_range(CPB - 1, CPB + 1);
         wait_cyc(gap);
         send_frame(rb, 1'b1, per, 1'b1);
      end
      wait_cyc(2);
      compare_events("rand");
      check_eq("rand_data", 32'(data_o), 32'(last_good));

      // Back-to-back frames, no idle gap.
      send_frame(8'h00, 1'b1, CPB, 1'b1);
      send_frame(8'hFF, 1'b1, CPB, 1'b1);
      send_frame(8'h55, 1'b1, CPB, 1'b1);
      wait_cyc(2);
      compare_events("b2b");
      check_eq("b2b_data", 32'(data_o), 32'h55);

      // Reset during bit 4 of 0x81, released while the line is high (bit 7).
      fork
         send_frame(8'h81, 1'b1, CPB, 1'b0);
         begin
            wait_cyc(5 * CPB + HALF);
            rst = 1'b1;
            wait_cyc(3);
            check_eq("mid_rst_data", 32'(data_o), 0);
            check_eq("mid_rst_busy", 32'(busy), 0);
            check_eq("mid_rst_done", 32'(rx_done), 0);
            last_good = 8'h00;
            wait_cyc(3 * CPB - 3);
            rst = 1'b0;
         end
      join
      wait_cyc(20);
      compare_events("rst_abort");
      check_eq("rst_abort_data", 32'(data_o), 0);
      send_frame(8'h7E, 1'b1, CPB, 1'b1);
      wait_cyc(2);
      compare_events("after_rst");
      check_eq("after_rst_data", 32'(data_o), 32'h7E);

      // Baud tolerance, slow and fast transmitter.
      send_frame(8'hC3, 1'b1, CPB - 1, 1'b1);
      wait_cyc(5);
      compare_events("tol_fast");
      send_frame(8'h00, 1'b1, CPB, 1'b1);
      send_frame(8'hC3, 1'b1, CPB + 1, 1'b1);
      wait_cyc(5);
      compare_events("tol_slow");
      check_eq("tol_data", 32'(data_o), 32'h C3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
